comb_str_8: RTL and testbench
=============================

COMB_STR_8 -- requirements
Module: comb_str_8

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 Port list, clock and reset first:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous reset, active-high.
- y    output 1  registered result.
- sel  input  1  function select.
- a    input  1  data bit A (MSB of ABCD).
- b    input  1  data bit B.
- c    input  1  data bit C.
- d    input  1  data bit D (LSB of ABCD).
REQ-004 Port declaration order SHALL be y, sel, a, b, c, d, clk, rst, so that positional instantiation with the first six ports matches the legacy pin order.

Function
REQ-005 The combinational core SHALL be gate-level structural, built from primitive gates (and, or, not, nand, nor, xor) only, with no behavioural assign or always for the logic.
REQ-006 When sel=0, the core SHALL compute f0 = NOT((a OR d) AND (b AND c AND NOT d)).
- Equivalent form: f0 = 0 only when ABCD=1110, else 1.
REQ-007 When sel=1, the core SHALL compute f1 = (a OR b) AND NOT(c AND d).
REQ-008 Selection between f0 and f1 SHALL use a structural 2:1 mux: (f0 AND NOT sel) OR (f1 AND sel).
REQ-009 The output y SHALL be a register loaded on each rising clk edge with the mux output.
- Latency: exactly 1 clock from the sampling edge to a valid y.
- There is no enable and no handshake.
REQ-010 Input changes between clock edges SHALL NOT affect y until the next rising edge; y SHALL be glitch-free.
REQ-011 X or Z on any input SHALL propagate per standard gate semantics, with no masking logic.
REQ-012 All 32 combinations of {sel,a,b,c,d} SHALL be legal, with no illegal or reserved codes.

Reset
REQ-013 When rst=1 at a rising clk edge, y SHALL become 0 at that edge, regardless of the other inputs.
REQ-014 Reset SHALL take priority over the data path when asserted at the same edge as an input change.
REQ-015 On the first rising edge with rst=0, y SHALL reflect the inputs sampled at that edge, with no extra recovery cycles.
REQ-016 Asserting reset mid-operation SHALL force y=0 at the next edge, and normal operation SHALL resume one edge after deassertion.
REQ-017 y SHALL be undefined before the first clock edge; the bench applies reset first.

Verification
REQ-018 Reset check: hold rst=1 for 2 edges with {sel,ABCD}=1_1000 -> y=0; deassert rst -> y=1 after the next edge.
REQ-019 sel=0 sweep, one edge apart:
- ABCD=0000 -> y=1
- ABCD=1110 -> y=0
- ABCD=1111 -> y=1
- ABCD=0110 -> y=1
REQ-020 sel=1 sweep:
- ABCD=0000 -> y=0
- ABCD=1000 -> y=1
- ABCD=0100 -> y=1
- ABCD=1011 -> y=0
- ABCD=1110 -> y=1
REQ-021 Exhaustive check: increment {sel,a,b,c,d} from 00000 to 11111, one step per clock.
- At each step, compare y against the REQ-006/REQ-007 reference model, delayed by 1 clock.
- Zero mismatches are required.
REQ-022 Latency and mid-cycle check:
- Change inputs from 0_1110 to 0_0000 between edges -> y stays 0 until the next rising edge, then becomes 1.
- Pulse an input for less than one clock period between edges -> y is unchanged.
REQ-023 Reset-collision check: assert rst at the same edge inputs move to 1_1000 -> y=0; release rst -> y=1 one edge later.

Source files
------------

// File: rtl/comb_str_8_if.sv
// comb_str_8_if
//   Groups the data-side signals of comb_str_8 so a driver and a receiver can
//   share one bundle. clk and rst are not part of the bundle.
//   Signals:
//      y    registered result from comb_str_8
//      sel  function select (0: f0, 1: f1)
//      a    data bit A (MSB of ABCD)
//      b    data bit B
//      c    data bit C
//      d    data bit D (LSB of ABCD)
//   Modports:
//      master  drives sel/a/b/c/d and observes y (the stimulus side)
//      slave   receives sel/a/b/c/d and produces y (the block side)
interface comb_str_8_if;
   logic y;
   logic sel;
   logic a;
   logic b;
   logic c;
   logic d;

   modport master (output sel, output a, output b, output c, output d, input y);
   modport slave  (input sel, input a, input b, input c, input d, output y);
endinterface

// File: rtl/comb_str_8.sv
// comb_str_8
//   Gate-level selectable boolean function with a registered output.
//     sel=0 : f0 = NOT((a OR d) AND (b AND c AND NOT d))   (0 only for ABCD=1110)
//     sel=1 : f1 = (a OR b) AND NOT(c AND d)
//   The selected value is captured into y on every rising clk edge, so y
//   follows the inputs with exactly one clock of latency and never glitches.
//   The port order keeps the legacy pin order for positional instantiation
//   of the first six ports; comb_str_8_if bundles the same data signals.
//   Ports:
//      y    output  registered result
//      sel  input   function select
//      a    input   data bit A (MSB of ABCD)
//      b    input   data bit B
//      c    input   data bit C
//      d    input   data bit D (LSB of ABCD)
//      clk  input   clock, rising edge active
//      rst  input   synchronous reset, active-high, forces y to 0
module comb_str_8 (
   output logic y,
   input  logic sel,
   input  logic a,
   input  logic b,
   input  logic c,
   input  logic d,
   input  logic clk,
   input  logic rst
);

   logic not_d;
   logic a_or_d;
   logic bc_not_d;
   logic f0_core;
   logic f0;
   logic a_or_b;
   logic not_cd;
   logic f1;
   logic not_sel;
   logic pick0;
   logic pick1;
   logic mux_out;

   // f0: the inverted product is zero only when b, c, a are high and d is low
   not  g_not_d   (not_d, d);
   or   g_a_or_d  (a_or_d, a, d);
   and  g_bcnd    (bc_not_d, b, c, not_d);
   and  g_f0_core (f0_core, a_or_d, bc_not_d);
   not  g_f0      (f0, f0_core);

   // f1
   or   g_a_or_b  (a_or_b, a, b);
   nand g_not_cd  (not_cd, c, d);
   and  g_f1      (f1, a_or_b, not_cd);

   // 2:1 select in sum-of-products form
   not  g_not_sel (not_sel, sel);
   and  g_pick0   (pick0, f0, not_sel);
   and  g_pick1   (pick1, f1, sel);
   or   g_mux     (mux_out, pick0, pick1);

   // output register stage; reset wins over the data path at the same edge
   always_ff @(posedge clk) begin
      if (rst) begin
         y <= 1'b0;
      end else begin
         y <= mux_out;
      end
   end

endmodule

// File: tb/tb_comb_str_8.sv
// tb_comb_str_8
//   Self-checking bench for comb_str_8: directed reset/sweep/latency/collision
//   vectors, an exhaustive walk of {sel,a,b,c,d}, and randomized vectors with
//   occasional reset, all checked against an arithmetic reference model.
module tb_comb_str_8;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   comb_str_8_if bus ();

   comb_str_8 dut (
      .y   (bus.y),
      .sel (bus.sel),
      .a   (bus.a),
      .b   (bus.b),
      .c   (bus.c),
      .d   (bus.d),
      .clk (clk),
      .rst (rst)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: value of the 4-bit number ABCD decides the result.
   //   sel=0 : 0 only when ABCD == 14
   //   sel=1 : (a|b) <=> ABCD >= 4 ; (c&d) <=> ABCD mod 4 == 3
   function automatic logic model_y(input logic s, input logic [3:0] abcd);
      int v;
      v = int'(abcd);
      if (!s) return (v != 14);
      return (v >= 4) && ((v % 4) != 3);
   endfunction

   task automatic check(input string tag, input logic got, input logic exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: y=%b expected %b at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic drive(input logic s, input logic [3:0] abcd);
      bus.sel = s;
      {bus.a, bus.b, bus.c, bus.d} = abcd;
   endtask

   // drive inputs, take one rising edge, settle just past it
   task automatic step(input logic s, input logic [3:0] abcd);
      drive(s, abcd);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   logic [3:0] sw0_in  [4] = '{4'b0000, 4'b1110, 4'b1111, 4'b0110};
   logic       sw0_exp [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
   logic [3:0] sw1_in  [5] = '{4'b0000, 4'b1000, 4'b0100, 4'b1011, 4'b1110};
   logic       sw1_exp [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

   initial begin
      logic [4:0] vec;
      logic       r;
      n_checks = 0;
      n_fail   = 0;

      // reset held for two edges with 1_1000 present
      rst = 1'b1;
      drive(1'b1, 4'b1000);
      @(posedge clk); #1;
      check("reset_edge1", bus.y, 1'b0);
      @(posedge clk); #1;
      check("reset_edge2", bus.y, 1'b0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("reset_release", bus.y, 1'b1);

      // sel=0 sweep
      for (int i = 0; i < 4; i++) begin
         step(1'b0, sw0_in[i]);
         check($sformatf("sel0_%b", sw0_in[i]), bus.y, sw0_exp[i]);
      end

      // sel=1 sweep
      for (int i = 0; i < 5; i++) begin
         step(1'b1, sw1_in[i]);
         check($sformatf("sel1_%b", sw1_in[i]), bus.y, sw1_exp[i]);
      end

      // exhaustive walk
      for (int i = 0; i < 32; i++) begin
         vec = 5'(i);
         step(vec[4], vec[3:0]);
         check($sformatf("exh_%b", vec), bus.y, model_y(vec[4], vec[3:0]));
      end

      // latency: change between edges must not reach y early
      step(1'b0, 4'b1110);
      check("lat_pre", bus.y, 1'b0);
      #2;
      drive(1'b0, 4'b0000);
      #1;
      check("lat_hold", bus.y, 1'b0);
      @(posedge clk); #1;
      check("lat_update", bus.y, 1'b1);

      // sub-cycle pulse to 0_1110 between edges is invisible
      #1;
      drive(1'b0, 4'b1110);
      #2;
      drive(1'b0, 4'b0000);
      #1;
      check("pulse_mid", bus.y, 1'b1);
      @(posedge clk); #1;
      check("pulse_edge", bus.y, 1'b1);

      // reset collides with an input change at the same edge
      step(1'b0, 4'b0000);
      check("coll_pre", bus.y, 1'b1);
      rst = 1'b1;
      step(1'b1, 4'b1000);
      check("coll_rst", bus.y, 1'b0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("coll_release", bus.y, 1'b1);

      // randomized vectors with occasional reset
      for (int i = 0; i < 300; i++) begin
         vec = 5'($urandom_range(0, 31));
         r   = ($urandom_range(0, 9) == 0);
         rst = r;
         step(vec[4], vec[3:0]);
         check($sformatf("rand_%0d_r%b_%b", i, r, vec), bus.y,
               r ? 1'b0 : model_y(vec[4], vec[3:0]));
      end
      rst = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
